uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 59 +++++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
// uart_tx_arbiter_if: bundles the requester side and transmitter side of the arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req_valid/req_data until the one-cycle req_ready strobe.
//
// Signals:
//   req_valid   [NUM_REQ]             per-requester word-available flags
//   req_data    [NUM_REQ*DATA_WIDTH]  packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   [NUM_REQ]             one-hot accept strobe (arbiter -> requesters)
//   tx_en                             transmitter enable level (arbiter -> transmitter)
//   tx_data     [DATA_WIDTH]          word presented to the transmitter
//   tx_done                           one-cycle frame-complete pulse (transmitter -> arbiter)
//   grant_id    [clog2(NUM_REQ)]      requester currently owning the transmitter
//   busy                              arbiter is not idle
//   timeout_err                       one-cycle pulse when a frame timed out
//
// Modports:
//   master  the arbiter's view (drives ready/transmit/status)
//   slave   the environment's view (requesters plus transmitter)
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_en;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_done;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic                          timeout_err;

  modport master (
    input  req_valid,
    input  req_data,
    input  tx_done,
    output req_ready,
    output tx_en,
    output tx_data,
    output grant_id,
    output busy,
    output timeout_err
  );

  modport slave (
    output req_valid,
    output req_data,
    output tx_done,
    input  req_ready,
    input  tx_en,
    input  tx_data,
    input  grant_id,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Latency: request seen in IDLE is accepted that cycle; tx_en rises the next cycle.
// Backpressure: req_ready only in IDLE; requesters hold valid/data until accepted.
//
// Ports:
//   clk    single system clock, rising edge
//   rst_n  asynchronous active-low reset; release takes effect on the next rising edge
//   bus    uart_tx_arbiter_if.master (requester handshake, transmitter control, status)
//
// Flow: IDLE picks a requester (round-robin from last_grant+1), captures its word and
// moves to SEND. SEND holds tx_en until tx_done or timeout, then GAP forces GAP_CYCLES
// idle cycles before the next arbitration.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  // The timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  // +1 keeps the width non-zero when GAP_CYCLES is 1.
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]            state;
  logic [TO_W-1:0]       to_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [ID_W-1:0]       last_grant;

  logic                  tx_en_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [ID_W-1:0]       grant_q;
  logic                  timeout_q;

  // Round-robin selection
  logic                  sel_found;
  logic [ID_W-1:0]       sel_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  int                    cand;

  // Walk NUM_REQ candidates starting just after the last winner; the first valid
  // one wins. Starting at last_grant+1 and wrapping gives every requester a turn
  // within NUM_REQ grants.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_data  = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(cand);
        sel_data  = bus.req_data[cand*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Accept strobe is combinational so a request present in IDLE is acknowledged in
  // the same cycle. It is gated by rst_n so no strobe escapes while reset is held.
  logic accept;
  assign accept = rst_n && (state == ST_IDLE) && sel_found;

  assign bus.req_ready   = accept ? (NUM_REQ'(1) << sel_idx) : '0;
  assign bus.tx_en       = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.timeout_err = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      last_grant <= ID_LAST;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // timeout_err is a single-cycle pulse; only the SEND timeout branch raises it.
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_SEND;
            tx_en_q    <= 1'b1;
            tx_data_q  <= sel_data;
            grant_q    <= sel_idx;
            last_grant <= sel_idx;
            to_cnt     <= '0;
          end
        end

        ST_SEND: begin
          // tx_done is checked first so a completion in the last allowed cycle
          // is a normal end of frame, not a timeout.
          if (bus.tx_done) begin
            state   <= ST_GAP;
            tx_en_q <= 1'b0;
            gap_cnt <= '0;
            to_cnt  <= '0;
          end else if (to_cnt == TO_LAST) begin
            state     <= ST_GAP;
            tx_en_q   <= 1'b0;
            timeout_q <= 1'b1;
            gap_cnt   <= '0;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          // tx_done arriving here is stale and deliberately ignored.
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          tx_en_q <= 1'b0;
          to_cnt  <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// tb_uart_tx_arbiter: randomized frames against a transaction-level round-robin model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;
  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int GAP = 2;
  localparam int TO  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_REQ       (NR),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_last;                 // model: index of the last accepted requester
  logic [DW-1:0] word [NR];   // words offered by each requester

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_words();
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = word[i];
  endtask

  // Round-robin rule: first asserted requester after the last winner, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] pat);
    for (int k = 1; k <= NR; k++) begin
      if (pat[(m_last + k) % NR]) return (m_last + k) % NR;
    end
    return -1;
  endfunction

  // One complete arbitration: accept, SEND, GAP, back to IDLE.
  // mode 0: tx_done after len SEND cycles; 1: no tx_done (timeout);
  // mode 2: tx_done in the final allowed cycle.
  task automatic run_frame(input logic [NR-1:0] pat, input int mode, input int len,
                           input bit hold);
    int w;
    int done_at;
    logic [NR-1:0] oh;
    logic [DW-1:0] exp_d;
    w = rr_pick(pat);
    oh = '0;
    oh[w] = 1'b1;
    exp_d = word[w];
    load_words();
    bus.req_valid = pat;
    #1;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("accept_ready", 32'(bus.req_ready), 32'(oh));
    step();
    m_last = w;
    if (!hold) bus.req_valid = '0;
    done_at = (mode == 0) ? len - 1 : (mode == 2) ? TO - 1 : -1;

    for (int k = 0; k < TO; k++) begin
      if (!hold) begin
        bus.req_valid = NR'($urandom);
        bus.req_data  = (NR*DW)'($urandom);
      end
      #1;
      chk("send_en", 32'(bus.tx_en), 1);
      chk("send_data", 32'(bus.tx_data), 32'(exp_d));
      chk("send_grant", 32'(bus.grant_id), 32'(w));
      chk("send_busy", 32'(bus.busy), 1);
      chk("send_ready", 32'(bus.req_ready), 0);
      chk("send_terr", 32'(bus.timeout_err), 0);
      if (k == done_at) bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      if (k == done_at) break;
    end

    for (int g = 0; g < GAP; g++) begin
      if (!hold) bus.req_valid = NR'($urandom);
      if (g < GAP - 1) bus.tx_done = 1'($urandom_range(0, 1));
      #1;
      chk("gap_en", 32'(bus.tx_en), 0);
      chk("gap_busy", 32'(bus.busy), 1);
      chk("gap_ready", 32'(bus.req_ready), 0);
      chk("gap_terr", 32'(bus.timeout_err), (g == 0 && mode == 1) ? 1 : 0);
      if (!hold) bus.req_valid = '0;
      step();
      bus.tx_done = 1'b0;
    end

    #1;
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_en", 32'(bus.tx_en), 0);
    if (!hold) chk("end_ready", 32'(bus.req_ready), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    for (int i = 0; i < NR; i++) word[i] = '0;
    repeat (3) @(negedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_en", 32'(bus.tx_en), 0);
    chk("rst_data", 32'(bus.tx_data), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NR - 1;

    // Single request from requester 2.
    word[2] = 8'hA5;
    run_frame(4'b0100, 0, 3, 1'b0);

    // Rotation: make 1 the last winner, then wrap to 0, then 3 ahead of 0.
    run_frame(4'b0010, 0, 2, 1'b0);
    run_frame(4'b0001, 0, 1, 1'b0);
    run_frame(4'b1001, 0, 4, 1'b0);

    // Contention: all valid continuously, order 0,1,2,3,0.
    for (int i = 0; i < NR; i++) word[i] = DW'(8'h10 + i);
    for (int f = 0; f < 5; f++) run_frame(4'b1111, 0, 1 + f, (f < 4));

    // Timeout, then collision of tx_done with the final timeout cycle.
    for (int i = 0; i < NR; i++) word[i] = DW'($urandom);
    run_frame(4'b0110, 1, 0, 1'b0);
    run_frame(4'b0110, 2, 0, 1'b0);
    run_frame(4'b1111, 1, 0, 1'b0);

    // Random traffic with stray tx_done pulses while idle.
    for (int f = 0; f < 40; f++) begin
      int r;
      logic [NR-1:0] pat;
      if ($urandom_range(0, 3) == 0) begin
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        #1;
        chk("idle_done_busy", 32'(bus.busy), 0);
        chk("idle_done_en", 32'(bus.tx_en), 0);
      end
      for (int i = 0; i < NR; i++) word[i] = DW'($urandom);
      pat = NR'($urandom_range(1, (1 << NR) - 1));
      r = $urandom_range(0, 9);
      if (r == 0)      run_frame(pat, 1, 0, 1'b0);
      else if (r == 1) run_frame(pat, 2, 0, 1'b0);
      else             run_frame(pat, 0, $urandom_range(1, TO - 1), 1'b0);
    end

    // Reset in the middle of SEND.
    for (int i = 0; i < NR; i++) word[i] = DW'($urandom | 1);
    load_words();
    bus.req_valid = '1;
    step();
    bus.req_valid = '1;
    #1;
    chk("pre_rst_en", 32'(bus.tx_en), 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(bus.tx_en), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_grant", 32'(bus.grant_id), 0);
    chk("mid_rst_data", 32'(bus.tx_data), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    step();
    step();
    #1;
    chk("held_rst_ready", 32'(bus.req_ready), 0);
    chk("held_rst_en", 32'(bus.tx_en), 0);
    rst_n = 1'b1;
    m_last = NR - 1;
    bus.req_valid = '0;
    run_frame(4'b1111, 0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
